// File: rtl/req_encoder16to4.sv
// Registered 16-to-4 priority encoder: sticky request capture, one code presented
// at a time under a valid/ack handshake.
module req_encoder16to4 #(
    parameter bit LSB_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t      state;
    logic [15:0] clr_mask;
    logic [3:0]  prio_idx;

    // Later matches overwrite earlier ones, so the scan order sets the winner.
    function automatic logic [3:0] prio_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (LSB_PRIORITY) begin
                if (v[15-i]) idx = 4'(15 - i);
            end else if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        clr_mask = 16'h0000;
        if (state == PRESENT && ack) clr_mask[code] = 1'b1;
    end

    assign prio_idx = prio_index(pending);
    assign busy     = (pending != 16'h0000) | valid;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 16'h0000;
            code    <= 4'h0;
            valid   <= 1'b0;
            state   <= IDLE;
        end else begin
            // Set wins over clear: a re-request in the acking cycle keeps the bit.
            pending <= (pending & ~clr_mask) | (en ? req : 16'h0000);
            case (state)
                IDLE: begin
                    if (pending != 16'h0000) begin
                        code  <= prio_idx;
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        code  <= 4'h0;
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_encoder16to4.sv
// Bench for req_encoder16to4: MSB- and LSB-priority instances against a set-based
// reference model, with a scoreboard of presented codes.
module tb_req_encoder16to4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        ack;

    logic [3:0]  code_a    [2];
    logic        valid_a   [2];
    logic [15:0] pending_a [2];
    logic        busy_a    [2];

    int n_tests = 0;
    int n_fail  = 0;

    bit [15:0] m_set  [2];
    bit        m_pres [2];
    int        m_code [2];
    int        exp_q0 [$];
    int        exp_q1 [$];

    bit        prev_valid [2];
    logic [3:0] prev_code [2];

    always #5 clk = ~clk;

    req_encoder16to4 #(.LSB_PRIORITY(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .code(code_a[0]), .valid(valid_a[0]), .pending(pending_a[0]), .busy(busy_a[0])
    );

    req_encoder16to4 #(.LSB_PRIORITY(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .code(code_a[1]), .valid(valid_a[1]), .pending(pending_a[1]), .busy(busy_a[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner index by arithmetic: floor(log2) of the set, or of its lowest set bit.
    function automatic int pick(input bit [15:0] s, input bit lsb);
        int v;
        v = int'(s);
        if (lsb) v = v & -v;
        return $clog2(v + 1) - 1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_set[i]  = 16'h0000;
                m_pres[i] = 1'b0;
                m_code[i] = 0;
            end else begin
                bit [15:0] nxt;
                nxt = m_set[i];
                if (m_pres[i] && ack) nxt[m_code[i]] = 1'b0;
                if (en) nxt = nxt | req;
                if (!m_pres[i]) begin
                    if (m_set[i] != 16'h0000) begin
                        m_code[i] = pick(m_set[i], i == 1);
                        m_pres[i] = 1'b1;
                        if (i == 0) exp_q0.push_back(m_code[i]);
                        else        exp_q1.push_back(m_code[i]);
                    end
                end else if (ack) begin
                    m_pres[i] = 1'b0;
                    m_code[i] = 0;
                end
                m_set[i] = nxt;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pending[%0d]", i), 32'(pending_a[i]), 32'(m_set[i]));
            check($sformatf("valid[%0d]", i), 32'(valid_a[i]), 32'(m_pres[i]));
            check($sformatf("code[%0d]", i), 32'(code_a[i]), 32'(m_code[i]));
            check($sformatf("busy[%0d]", i), 32'(busy_a[i]),
                  32'((m_set[i] != 16'h0000) || m_pres[i]));
        end
    endtask

    // Called at a falling edge: drive, clock, update model, compare, return at next falling edge.
    task automatic cycle(input bit r, input bit e, input bit [15:0] rq, input bit a);
        rst = r;
        en  = e;
        req = rq;
        ack = a;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Scoreboard monitor: each new presentation pops one expected code; held codes must not move.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (valid_a[i] === 1'b1 && !prev_valid[i]) begin
                int exp_code;
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected[%0d]: got code %0h, expected no presentation", i, code_a[i]);
                end else begin
                    exp_code = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("sb_code[%0d]", i), 32'(code_a[i]), 32'(exp_code));
                end
            end else if (valid_a[i] === 1'b1 && prev_valid[i]) begin
                check($sformatf("hold_code[%0d]", i), 32'(code_a[i]), 32'(prev_code[i]));
            end
            prev_valid[i] = (valid_a[i] === 1'b1);
            prev_code[i]  = code_a[i];
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 16'h0000;
        ack = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 16'h0000, 0);
        check("reset_code", 32'(code_a[0]), 32'h0);
        check("reset_busy", 32'(busy_a[0]), 32'h0);

        // Single request round trip
        cycle(0, 1, 16'h0010, 0);
        check("t1_pending", 32'(pending_a[0]), 32'h0010);
        cycle(0, 0, 16'h0000, 0);
        check("t1_code", 32'(code_a[0]), 32'h4);
        check("t1_valid", 32'(valid_a[0]), 32'h1);
        cycle(0, 0, 16'h0000, 1);
        check("t1_busy_after_ack", 32'(busy_a[0]), 32'h0);

        // Three requests, ack tied high
        cycle(0, 1, 16'h8011, 1);
        for (int k = 0; k < 7; k++) cycle(0, 0, 16'h0000, 1);
        check("t2_drained", 32'(busy_a[0]), 32'h0);

        // No preemption while presenting
        cycle(0, 1, 16'h0010, 0);
        cycle(0, 0, 16'h0000, 0);
        cycle(0, 1, 16'h8000, 0);
        check("t3_hold_code", 32'(code_a[0]), 32'h4);
        check("t3_pending", 32'(pending_a[0]), 32'h8010);
        cycle(0, 0, 16'h0000, 1);
        cycle(0, 0, 16'h0000, 0);
        check("t3_next_code", 32'(code_a[0]), 32'hF);
        cycle(0, 0, 16'h0000, 1);
        cycle(0, 0, 16'h0000, 0);

        // Capture disabled
        for (int k = 0; k < 5; k++) cycle(0, 0, 16'hFFFF, 0);
        check("t4_blocked", 32'(pending_a[0]), 32'h0);
        cycle(0, 1, 16'h0001, 0);
        cycle(0, 0, 16'h0000, 0);
        check("t4_code0", 32'(code_a[0]), 32'h0);
        cycle(0, 0, 16'h0000, 1);
        cycle(0, 0, 16'h0000, 0);

        // Set wins over ack-clear
        cycle(0, 1, 16'h0010, 0);
        cycle(0, 0, 16'h0000, 0);
        cycle(0, 1, 16'h0010, 1);
        check("t5_sticky", 32'(pending_a[0]), 32'h0010);
        cycle(0, 0, 16'h0000, 0);
        check("t5_represent", 32'(code_a[0]), 32'h4);
        cycle(0, 0, 16'h0000, 1);
        cycle(0, 0, 16'h0000, 0);

        // Reset mid-presentation, ack in the reset cycle
        cycle(0, 1, 16'h8011, 0);
        cycle(0, 0, 16'h0000, 0);
        check("t6_code15", 32'(code_a[0]), 32'hF);
        cycle(1, 1, 16'hFFFF, 1);
        check("t6_pending", 32'(pending_a[0]), 32'h0);
        check("t6_busy", 32'(busy_a[0]), 32'h0);

        // All 16 pending, ack tied high: 32 cycles to drain
        cycle(0, 1, 16'hFFFF, 1);
        for (int k = 0; k < 32; k++) cycle(0, 0, 16'h0000, 1);
        check("all16_drained_msb", 32'(busy_a[0]), 32'h0);
        check("all16_drained_lsb", 32'(busy_a[1]), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            bit        r;
            bit [15:0] rq;
            r  = ($urandom_range(63) == 0);
            rq = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom & $urandom & $urandom);
            cycle(r, $urandom_range(3) != 0, rq, $urandom_range(1) == 1);
        end

        // Drain remaining work, bounded
        for (int k = 0; k < 40; k++) cycle(0, 0, 16'h0000, 1);
        check("final_idle_msb", 32'(busy_a[0]), 32'h0);
        check("final_idle_lsb", 32'(busy_a[1]), 32'h0);
        check("sb_leftover_msb", 32'(exp_q0.size()), 32'h0);
        check("sb_leftover_lsb", 32'(exp_q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/req_encoder16to4.md
Name: req_encoder16to4

Overview:
- Registered 16-to-4 priority encoder with sticky request capture and a valid/ack handshake.
- It is the inverse of the team's 4-to-16 decoder: it turns up to 16 one-hot event lines back into a 4-bit index.
- Captured events are served one at a time, highest priority first.
- Sits between event/request sources and any consumer that needs a binary index, e.g. a 4-to-16 decoder selecting a responder.

Parameters:
- LSB_PRIORITY, default 0. 0 means the highest set index wins; 1 means the lowest set index wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 0, req is ignored.
- req  input  16  request/event lines, one bit per source, sampled every edge.
- ack  input  1  consumer accepts the presented code.
- code  output  4  index of the request being presented.
- valid  output  1  code is valid and held stable.
- pending  output  16  current sticky pending register.
- busy  output  1  high when pending is nonzero or valid is 1.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=16'h0000, code=4'h0, valid=0, state=IDLE.
  - req and ack are ignored in that cycle.
  - A reset mid-handshake discards everything, with no partial clear.
- Capture, each non-reset edge:
  - pending <= (pending & ~clr_mask) | (en ? req : 16'h0000).
  - clr_mask is one-hot at code when state=PRESENT and ack=1; otherwise it is 0.
  - Set wins: if req[code] arrives in the acking cycle, the bit stays set and is served again later.
- FSM, two states:
  - IDLE: if registered pending != 0:
    - code <= priority index of pending (MSB-first, or LSB-first if LSB_PRIORITY=1).
    - valid <= 1, go to PRESENT.
    - Otherwise stay in IDLE with valid=0.
  - IDLE decisions use the registered pending only, never the live req.
  - PRESENT: code and valid are held stable until ack=1.
    - No preemption: a higher-priority request arriving meanwhile only sets pending.
    - On ack=1: valid <= 0, code <= 4'h0, pending bit cleared as above, go to IDLE.
- Latency:
  - req sampled at edge k sets pending after edge k.
  - valid/code are visible after edge k+1.
  - After the ack edge there is one bubble cycle with valid=0.
  - Maximum throughput is one code per 2 cycles.
- Handshake:
  - ack while valid=0 is ignored.
  - ack held high continuously yields one accept per presentation.
- en=0 blocks new capture only; already pending bits are still served.
- busy is combinational: (pending != 0) | valid.
- Bounds:
  - All 16 bits pending: 16 presentations, 32 cycles with ack tied high, then busy=0.
  - Index 15 and index 0 both encode correctly; there is no wrap-around.

Test Plan:
1. Reset, then en=1, req=16'h0010 for 1 cycle -> pending=16'h0010 after that edge; code=4 and valid=1 one edge later; ack=1 -> valid=0, pending=0, busy=0.
2. LSB_PRIORITY=0, req=16'h8011 in one cycle, ack tied 1 -> codes 15, 4, 0 in order, valid high every other cycle, pending empty after 6 cycles.
3. While code=4 is presented with ack=0, pulse req=16'h8000 -> code stays 4 and valid stays 1 (no preemption), pending=16'h8010; ack -> next code is 15.
4. en=0 with req=16'hFFFF for 5 cycles -> pending stays 0 and valid stays 0; then en=1 for one cycle with req=16'h0001 -> code=0, valid=1.
5. Present code=4; in the same cycle ack=1 and req=16'h0010 -> pending[4] remains 1, code 4 is presented again after the bubble cycle.
6. Mid-presentation (code=15, pending=16'h8011), assert rst for 1 cycle -> valid=0, code=0, pending=0, busy=0; ack in the reset cycle has no effect.
